// File: rtl/sht40_measure_sequencer.sv
// SHT40 measurement sequencer: command write, conversion wait, 6-byte read, CRC-8 check, publish; period or software trigger.
// Latency start->done = 1 + write bus + CONV_CYCLES + read bus + 32 + 1 cycles; requests outside IDLE are dropped. Build macro SHT_CRC_RETRY_EN enables one re-read after a CRC failure.
module sht40_measure_sequencer #(
   parameter logic [6:0] SHT_ADDR       = 7'h44,
   parameter logic [7:0] MEAS_CMD       = 8'hFD,
   parameter int         CONV_CYCLES    = 200000,
   parameter int         TIMEOUT_CYCLES = 65535,
   parameter int         PERIOD_CYCLES  = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [15:0] temp_raw,
   output logic [15:0] hum_raw,
   output logic        Processor_Ready,
   output logic [6:0]  Peripheral_Address,
   output logic [7:0]  Command_Data_Frames,
   output logic        r_or_w,
   output logic        i2c_writes,
   output logic [3:0]  SHT_Reads,
   output logic        CRC_Error,
   input  logic [2:0]  Master_State_Out,
   input  logic [3:0]  Output_Received_Counter,
   input  logic [7:0]  Data_Received
);
   localparam logic [3:0] S_IDLE = 4'd0, S_WR_LAUNCH = 4'd1, S_WR_WAIT = 4'd2, S_CONV = 4'd3,
                          S_RD_LAUNCH = 4'd4, S_RD_COLLECT = 4'd5, S_CHECK = 4'd6, S_ABORT = 4'd7,
                          S_AB_WAIT = 4'd8, S_DONE = 4'd9, S_ERROR = 4'd10;
   localparam logic [31:0] TO_LIM    = 32'(TIMEOUT_CYCLES);
   localparam logic [31:0] CONV_LAST = (CONV_CYCLES > 0) ? 32'(CONV_CYCLES - 1) : 32'd0;
   localparam logic [31:0] PER_LAST  = (PERIOD_CYCLES > 0) ? 32'(PERIOD_CYCLES - 1) : 32'd0;

   logic [3:0]  state, state_nxt;
   logic [31:0] cnt, per_cnt;
   logic        seen, temp_bad;
   logic [3:0]  orc_prev;
   logic [2:0]  nbytes;
   logic [7:0]  rx [6];
   logic [7:0]  crc, crc_in, crc_step;
   logic [1:0]  code_pend, crc_code;
   logic [15:0] word;
   logic        mst_idle, per_fire, req, capture, wd_exp, crc_bit, crc_fail, retry_ok;

   assign mst_idle = (Master_State_Out == 3'b000);
   assign per_fire = (PERIOD_CYCLES > 0) && (per_cnt == PER_LAST);
   assign req      = (state == S_IDLE) && (start || per_fire);
   assign capture  = (state == S_RD_COLLECT) && (Output_Received_Counter != orc_prev);
   assign wd_exp   = (cnt == TO_LIM);

   // One CRC bit per CHECK cycle: cnt 0..15 covers the temperature word, 16..31 the humidity word.
   assign word     = cnt[4] ? {rx[3], rx[4]} : {rx[0], rx[1]};
   assign crc_bit  = word[4'd15 - cnt[3:0]];
   assign crc_in   = (cnt[3:0] == 4'd0) ? 8'hFF : crc;
   assign crc_step = {crc_in[6:0], 1'b0} ^ ((crc_in[7] ^ crc_bit) ? 8'h31 : 8'h00);
   assign crc_fail = temp_bad || (crc_step != rx[5]);
   assign crc_code = temp_bad ? 2'b10 : 2'b11;

`ifdef SHT_CRC_RETRY_EN
   logic retried;
   assign retry_ok = !retried;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         retried <= 1'b0;
      else if (req)
         retried <= 1'b0;
      else if (state_nxt == S_RD_LAUNCH && state != S_CONV)
         retried <= 1'b1;
   end
`else
   assign retry_ok = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:       if (req) state_nxt = S_WR_LAUNCH;
         S_WR_LAUNCH:  state_nxt = S_WR_WAIT;
         S_WR_WAIT:    if (seen && mst_idle) state_nxt = S_CONV;
                       else if (wd_exp) state_nxt = S_ERROR;
         S_CONV:       if (cnt >= CONV_LAST) state_nxt = S_RD_LAUNCH;
         S_RD_LAUNCH:  state_nxt = S_RD_COLLECT;
         S_RD_COLLECT: if (capture && nbytes == 3'd5) state_nxt = S_CHECK;
                       else if (!capture && ((seen && mst_idle) || wd_exp)) state_nxt = S_ERROR;
         S_CHECK:      if (cnt[4:0] == 5'd31) begin
                          if (!crc_fail) state_nxt = S_DONE;
                          else if (!mst_idle) state_nxt = S_ABORT;
                          else state_nxt = retry_ok ? S_RD_LAUNCH : S_ERROR;
                       end
         S_ABORT:      state_nxt = S_AB_WAIT;
         S_AB_WAIT:    if (mst_idle) state_nxt = retry_ok ? S_RD_LAUNCH : S_ERROR;
                       else if (wd_exp) state_nxt = S_ERROR;
         default:      state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         per_cnt   <= '0;
         seen      <= 1'b0;
         temp_bad  <= 1'b0;
         orc_prev  <= '0;
         nbytes    <= '0;
         crc       <= '0;
         code_pend <= '0;
         err_code  <= '0;
         temp_raw  <= '0;
         hum_raw   <= '0;
         r_or_w    <= 1'b1;
         for (int i = 0; i < 6; i++) rx[i] <= '0;
      end else begin
         state    <= state_nxt;
         orc_prev <= Output_Received_Counter;
         // Shared counter: conversion wait, per-phase watchdog and CRC bit index.
         if (state_nxt != state || capture || state == S_IDLE)
            cnt <= '0;
         else
            cnt <= cnt + 32'd1;
         seen <= (state_nxt != state) ? 1'b0 : (seen | !mst_idle);
         if (req)
            per_cnt <= '0;
         else if (state == S_IDLE && PERIOD_CYCLES > 0)
            per_cnt <= per_cnt + 32'd1;
         if (state == S_RD_LAUNCH)
            nbytes <= '0;
         else if (capture) begin
            rx[nbytes] <= Data_Received;
            nbytes     <= nbytes + 3'd1;
         end
         if (state == S_CHECK) begin
            crc <= crc_step;
            if (cnt[4:0] == 5'd15) temp_bad <= (crc_step != rx[2]);
            if (cnt[4:0] == 5'd31) code_pend <= crc_code;
         end
         if (req)
            err_code <= 2'b00;
         else if (state_nxt == S_ERROR) begin
            if (state == S_CHECK) err_code <= crc_code;
            else if (state == S_AB_WAIT && mst_idle) err_code <= code_pend;
            else err_code <= 2'b01;
         end
         if (state == S_CHECK && state_nxt == S_DONE) begin
            temp_raw <= {rx[0], rx[1]};
            hum_raw  <= {rx[3], rx[4]};
         end
         if (state_nxt == S_WR_LAUNCH) r_or_w <= 1'b1;
         else if (state_nxt == S_RD_LAUNCH) r_or_w <= 1'b0;
      end
   end

   assign busy                = (state != S_IDLE);
   assign done                = (state == S_DONE);
   assign err                 = (state == S_ERROR);
   assign Processor_Ready     = (state == S_WR_LAUNCH) || (state == S_RD_LAUNCH);
   assign CRC_Error           = (state == S_ABORT);
   assign Peripheral_Address  = SHT_ADDR;
   assign Command_Data_Frames = MEAS_CMD;
   assign i2c_writes          = 1'b0;
   assign SHT_Reads           = 4'd5;
endmodule

// File: tb/tb_sht40_measure_sequencer.sv
// Bench for sht40_measure_sequencer: i2c_master behavioural model, vector table and scoreboard of published words.
`timescale 1ns/1ps
module tb_sht40_measure_sequencer;
   localparam int TO = 300, PER = 1000, CONV = 10;
`ifdef SHT_CRC_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic busy, done, err, Processor_Ready, r_or_w, i2c_writes, CRC_Error;
   logic [1:0] err_code;
   logic [15:0] temp_raw, hum_raw;
   logic [6:0] Peripheral_Address;
   logic [7:0] Command_Data_Frames, drx;
   logic [3:0] SHT_Reads, orc;
   logic [2:0] mso;

   always #5 clk = ~clk;

   sht40_measure_sequencer #(.CONV_CYCLES(CONV), .TIMEOUT_CYCLES(TO), .PERIOD_CYCLES(PER)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
      .err_code(err_code), .temp_raw(temp_raw), .hum_raw(hum_raw),
      .Processor_Ready(Processor_Ready), .Peripheral_Address(Peripheral_Address),
      .Command_Data_Frames(Command_Data_Frames), .r_or_w(r_or_w), .i2c_writes(i2c_writes),
      .SHT_Reads(SHT_Reads), .CRC_Error(CRC_Error), .Master_State_Out(mso),
      .Output_Received_Counter(orc), .Data_Received(drx));

   int checks = 0, errors = 0, cyc = 0;
   int pr_cnt = 0, crc_cnt = 0, done_cnt = 0, err_cnt = 0, pr_cyc = 0, err_cyc = 0;
   logic [31:0] exp_q[$];
   logic [47:0] frames[$];
   bit hang = 1'b0, stop3 = 1'b0;
   int m_phase = 0, m_cnt = 0, m_idx = 0;
   logic [47:0] m_frame = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] crc8(input logic [15:0] w);
      logic [7:0] c = 8'hFF;
      for (int i = 15; i >= 0; i--) c = (c[7] ^ w[i]) ? ((c << 1) ^ 8'h31) : (c << 1);
      return c;
   endfunction

   function automatic logic [47:0] mk(input logic [15:0] t, input logic [15:0] h);
      return {t, crc8(t), h, crc8(h)};
   endfunction

   // Master model: 5-cycle write, one byte every 3 cycles on read, then 110 for 40 cycles unless aborted.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mso <= '0; orc <= '0; drx <= '0; m_phase <= 0; m_cnt <= 0; m_idx <= 0;
      end else begin
         case (m_phase)
            0: if (Processor_Ready) begin
                  m_cnt <= 0; m_idx <= 0;
                  if (r_or_w) begin
                     mso <= hang ? 3'b010 : 3'b001;
                     m_phase <= hang ? 4 : 1;
                  end else begin
                     m_frame <= (frames.size() > 0) ? frames.pop_front() : 48'h0;
                     mso <= 3'b010;
                     m_phase <= 2;
                  end
               end
            1: begin
                  m_cnt <= m_cnt + 1;
                  if (m_cnt == 4) begin mso <= '0; m_phase <= 0; end
               end
            2: begin
                  m_cnt <= m_cnt + 1;
                  if (m_cnt % 3 == 2 && !(stop3 && m_idx == 3)) begin
                     drx <= m_frame[47 - 8*m_idx -: 8];
                     orc <= orc + 4'd1;
                     m_idx <= m_idx + 1;
                     if (m_idx == 5) begin m_phase <= 3; mso <= 3'b110; m_cnt <= 0; end
                  end
               end
            3: begin
                  m_cnt <= m_cnt + 1;
                  if (CRC_Error || m_cnt == 39) begin mso <= '0; m_phase <= 0; end
               end
            default: if (!hang) begin mso <= '0; m_phase <= 0; end
         endcase
      end
   end

   // Monitor and scoreboard: every done pops the expected {temp, hum} pair.
   always @(negedge clk) begin
      if (rst_n) begin
         if (Processor_Ready) begin pr_cnt++; pr_cyc = cyc; end
         if (CRC_Error) crc_cnt++;
         if (err) begin err_cnt++; err_cyc = cyc; end
         if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_unexpected_done temp=%0h hum=%0h", temp_raw, hum_raw);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               check("sb_temp", {16'h0, temp_raw}, {16'h0, e[31:16]});
               check("sb_hum", {16'h0, hum_raw}, {16'h0, e[15:0]});
            end
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_master_idle();
      for (int n = 0; n < 200 && !(m_phase == 0 && mso == 3'b000); n++) @(posedge clk);
      @(posedge clk);
   endtask

   task automatic wait_end(input int d0, input int e0, input int limit, input string name);
      for (int n = 0; n < limit && done_cnt == d0 && err_cnt == e0; n++) @(posedge clk);
      if (done_cnt == d0 && err_cnt == e0) begin
         checks++; errors++;
         $display("FAIL %s no done/err within %0d cycles", name, limit);
      end
      @(posedge clk);
   endtask

   typedef struct {
      logic [47:0] f1, f2, fx;
      bit exp_done;
      logic [1:0] code;
      int prs, crcs;
   } vec_t;
   vec_t vt[6];

   initial begin
      #800000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      logic [47:0] nom, bad_t, bad_h, bad_b;
      logic [15:0] last_t, last_h;
      int p0, c0, d0, e0, r1, r2, len;
      nom   = 48'hBEEF92666693;
      bad_t = 48'hBEEF93666693;
      bad_h = 48'hBEEF92666694;
      bad_b = 48'hBEEF93666694;
      vt[0] = '{nom,   48'h0, nom, 1'b1,  2'b00, 2, 0};
      vt[1] = '{bad_t, nom,   nom, RETRY, 2'b10, RETRY ? 3 : 2, 1};
      vt[2] = '{bad_h, nom,   nom, RETRY, 2'b11, RETRY ? 3 : 2, 1};
      vt[3] = '{bad_b, nom,   nom, RETRY, 2'b10, RETRY ? 3 : 2, 1};
      vt[4] = '{mk(16'h0000, 16'hFFFF), 48'h0, mk(16'h0000, 16'hFFFF), 1'b1, 2'b00, 2, 0};
      vt[5] = '{mk(16'h1234, 16'hABCD), 48'h0, mk(16'h1234, 16'hABCD), 1'b1, 2'b00, 2, 0};
      last_t = '0; last_h = '0;

      // Reset values
      #23;
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done_err", {30'h0, done, err}, 32'h0);
      check("rst_err_code", {30'h0, err_code}, 32'h0);
      check("rst_temp_hum", {temp_raw, hum_raw}, 32'h0);
      check("rst_pready_crcerr", {30'h0, Processor_Ready, CRC_Error}, 32'h0);
      check("rst_addr", {25'h0, Peripheral_Address}, 32'h44);
      check("rst_cmd", {24'h0, Command_Data_Frames}, 32'hFD);
      check("rst_rw_writes", {30'h0, r_or_w, i2c_writes}, 32'h2);
      check("rst_sht_reads", {28'h0, SHT_Reads}, 32'h5);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // Table-driven measurements
      for (int i = 0; i < 6; i++) begin
         wait_master_idle();
         frames.delete();
         frames.push_back(vt[i].f1);
         if (vt[i].f2 != 48'h0) frames.push_back(vt[i].f2);
         if (vt[i].exp_done) exp_q.push_back({vt[i].fx[47:32], vt[i].fx[23:8]});
         p0 = pr_cnt; c0 = crc_cnt; d0 = done_cnt; e0 = err_cnt;
         pulse_start();
         wait_end(d0, e0, 1000, $sformatf("vec%0d_end", i));
         check($sformatf("vec%0d_done", i), done_cnt - d0, {31'h0, vt[i].exp_done});
         check($sformatf("vec%0d_err", i), err_cnt - e0, {31'h0, !vt[i].exp_done});
         check($sformatf("vec%0d_pready", i), pr_cnt - p0, vt[i].prs);
         check($sformatf("vec%0d_crc_error", i), crc_cnt - c0, vt[i].crcs);
         if (vt[i].exp_done) begin
            check($sformatf("vec%0d_err_code_clear", i), {30'h0, err_code}, 32'h0);
            last_t = vt[i].fx[47:32]; last_h = vt[i].fx[23:8];
         end else begin
            check($sformatf("vec%0d_err_code", i), {30'h0, err_code}, {30'h0, vt[i].code});
            check($sformatf("vec%0d_raw_held", i), {temp_raw, hum_raw}, {last_t, last_h});
         end
         check($sformatf("vec%0d_busy_low", i), {31'h0, busy}, 32'h0);
      end

      // Hung bus during the command write
      wait_master_idle();
      hang = 1'b1;
      p0 = pr_cnt; d0 = done_cnt; e0 = err_cnt;
      pulse_start();
      wait_end(d0, e0, TO + 100, "hung_end");
      check("hung_err_delay", err_cyc - pr_cyc, TO + 2);
      check("hung_err_code", {30'h0, err_code}, 32'h1);
      check("hung_pready", pr_cnt - p0, 1);
      hang = 1'b0;
      repeat (3) @(posedge clk);

      // Start pulses while busy are dropped
      wait_master_idle();
      frames.delete();
      frames.push_back(nom);
      exp_q.push_back(32'hBEEF6666);
      p0 = pr_cnt; d0 = done_cnt;
      pulse_start();
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         if (done || !busy) begin start = 1'b0; break; end
         start = (k % 4 == 0);
      end
      start = 1'b0;
      repeat (20) @(posedge clk);
      check("busy_start_pready", pr_cnt - p0, 2);
      check("busy_start_done", done_cnt - d0, 1);
      check("busy_start_idle", {31'h0, busy}, 32'h0);

      // Reset in the middle of the read, after three bytes
      wait_master_idle();
      frames.delete();
      frames.push_back(nom);
      stop3 = 1'b1;
      pulse_start();
      for (int n = 0; n < 300 && m_idx < 3; n++) @(posedge clk);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_temp_hum", {temp_raw, hum_raw}, 32'h0);
      check("midrst_busy", {31'h0, busy}, 32'h0);
      check("midrst_rw_pready", {30'h0, r_or_w, Processor_Ready}, 32'h2);
      stop3 = 1'b0;
      frames.delete();
      @(negedge clk) rst_n = 1'b1;
      frames.push_back(mk(16'h0102, 16'h0304));
      exp_q.push_back(32'h01020304);
      d0 = done_cnt; e0 = err_cnt;
      pulse_start();
      wait_end(d0, e0, 1000, "after_rst_end");
      check("after_rst_done", done_cnt - d0, 1);
      check("after_rst_err", err_cnt - e0, 0);

      // Period timer: spacing of two auto-triggered acceptances
      wait_master_idle();
      frames.delete();
      frames.push_back(nom); frames.push_back(nom);
      exp_q.push_back(32'hBEEF6666); exp_q.push_back(32'hBEEF6666);
      r1 = -1; r2 = -1; len = 0;
      for (int n = 0; n < PER + 200 && !busy; n++) @(negedge clk);
      r1 = cyc;
      for (int n = 0; n < 1000 && busy; n++) begin len++; @(negedge clk); end
      for (int n = 0; n < PER + 200 && !busy; n++) @(negedge clk);
      r2 = cyc;
      check("period_spacing", r2 - r1, len + PER);
      d0 = done_cnt; e0 = err_cnt;
      wait_end(d0, e0, 1000, "period_second_end");
      check("period_sb_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sht40_measure_sequencer.md
Name: sht40_measure_sequencer

Overview:
- Sequences `i2c_master` through a complete SHT40 measurement: write command, wait for conversion, read 6 bytes, check both CRCs, then publish the results.
- Sits between `i2c_master` and the sensor-facing logic, and is the only driver of the master's control inputs.
- Starts on a software trigger or on a free-running period timer.
- Times out on a hung bus and reports errors with a code.

Parameters:
- SHT_ADDR, 7'h44, 7-bit I2C address of the sensor.
- MEAS_CMD, 8'hFD, measurement command byte (high precision).
- CONV_CYCLES, 200000, clk cycles to wait between the command write and the data read (10 ms at 20 MHz).
- TIMEOUT_CYCLES, 65535, maximum clk cycles allowed in any single bus phase.
- PERIOD_CYCLES, 0, auto-trigger period in clk cycles; 0 disables the period timer.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle measurement request
- busy  out  1  high from request acceptance until done or err
- done  out  1  one-cycle pulse when results are valid
- err  out  1  one-cycle pulse on failure
- err_code  out  2  01 = timeout, 10 = temperature CRC, 11 = humidity CRC; held until the next start
- temp_raw  out  16  last good temperature word
- hum_raw  out  16  last good humidity word
- Processor_Ready  out  1  to master, one-cycle launch strobe
- Peripheral_Address  out  7  to master
- Command_Data_Frames  out  8  to master
- r_or_w  out  1  to master, 1 = write, 0 = read
- i2c_writes  out  1  to master, always 0
- SHT_Reads  out  4  to master, always 4'd5
- CRC_Error  out  1  to master, abort strobe
- Master_State_Out  in  3  from master, 000 = idle, 110 = end
- Output_Received_Counter  in  4  from master
- Data_Received  in  8  from master

Behaviour:
- **Reset values:** all outputs 0 except Peripheral_Address = SHT_ADDR, Command_Data_Frames = MEAS_CMD, SHT_Reads = 5, r_or_w = 1. State IDLE, all counters 0.
- **Reset mid-operation:** returns to IDLE immediately. temp_raw and hum_raw clear to 0.
- **Request acceptance:**
  - start (or the period timer expiring) is accepted only in IDLE.
  - start while busy is ignored and not queued.
  - busy rises the cycle after acceptance.
- **Period timer:** counts only in IDLE when PERIOD_CYCLES > 0. It reloads on any acceptance.
- **States:**
  - IDLE: wait for a request.
  - WR_LAUNCH: r_or_w = 1, Processor_Ready = 1 for exactly one cycle, then go to WR_WAIT.
  - WR_WAIT: wait until Master_State_Out != 000 has been seen and then Master_State_Out == 000, then go to CONV.
  - CONV: count CONV_CYCLES, then go to RD_LAUNCH.
  - RD_LAUNCH: r_or_w = 0, Processor_Ready pulse, go to RD_COLLECT.
  - RD_COLLECT:
    - On each change of Output_Received_Counter, capture Data_Received into byte slot n, n = 0..5.
    - On the 6th capture, go to CHECK.
    - A 6th byte must be captured before Master_State_Out returns to 000; otherwise treat it as a timeout.
  - CHECK:
    - Compute CRC-8 (polynomial 0x31, init 0xFF, no reflection, no final XOR) serially over bytes 0–1, then bytes 3–4, one bit per cycle, 32 cycles total.
    - Compare against byte 2 and byte 5.
  - DONE: temp_raw = {b0,b1}, hum_raw = {b3,b4}, pulse done, busy low next cycle, go to IDLE.
  - ERROR: pulse err, set err_code, busy low, go to IDLE. temp_raw and hum_raw are not updated.
- **CRC failure:** if the master is still not at 000, pulse CRC_Error for one cycle and then wait for 000 (still subject to timeout).
- **Priority:** if both CRCs fail, err_code = 10.
- **Timeout:** a per-phase watchdog runs in WR_WAIT, RD_COLLECT and the post-abort wait. It reloads on every state change and on every byte capture. Expiry goes to ERROR with err_code = 01.
- **Latency:** from start to done = 1 + write bus time + CONV_CYCLES + read bus time + 32 + 1 cycles.

Optional Feature:
- Macro SHT_CRC_RETRY_EN.
- When defined: on the first CRC failure in a measurement, the block re-enters RD_LAUNCH once, without a new command write; busy stays high. A second failure goes to ERROR.
- When not defined: any CRC failure goes to ERROR directly.
- Timeouts never retry in either build.

Test Plan:
- **Nominal:** start, master model returns bytes BE EF 92 66 66 93 → done pulse; temp_raw = 16'hBEEF, hum_raw = 16'h6666; err never asserted.
- **Bad temperature CRC:** byte 2 = 0x93 → without SHT_CRC_RETRY_EN: CRC_Error pulse, err pulse, err_code = 10. With the macro: a second Processor_Ready read launch, and done on clean data.
- **Hung bus:** master held at 010 after WR_LAUNCH → err pulse exactly TIMEOUT_CYCLES+1 cycles after entering WR_WAIT; err_code = 01.
- **Start while busy:** start pulses in CONV and RD_COLLECT → no extra Processor_Ready and a single done.
- **Reset during RD_COLLECT** after 3 bytes → outputs at reset values; a fresh start completes normally with the correct byte order.
- **Period mode:** PERIOD_CYCLES = 1000, CONV_CYCLES = 10 → consecutive accepted requests spaced 1000 cycles plus the measurement time apart.
